// File: rtl/test_pattern_gen.sv
// Write-side stimulus source for the logic-analyzer circular buffer: streams an
// incrementing pattern, fires the capture trigger and tags each word with its check data.
module test_pattern_gen #(
    parameter int DATA_WIDTH      = 8,
    parameter int MEMORY_SIZE     = 32,
    parameter int USER_HOLDOFF    = 8,
    parameter int ALIGNMENT_DELAY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  wr_ready,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  trigger_out,
    output logic                  check_window,
    output logic [DATA_WIDTH-1:0] expected_out,
    output logic                  busy,
    output logic                  done
);

    localparam int TOTAL  = 2 * MEMORY_SIZE + USER_HOLDOFF + ALIGNMENT_DELAY;
    localparam int CW     = $clog2(TOTAL + 1);
    localparam int WIN_LO = MEMORY_SIZE + USER_HOLDOFF + ALIGNMENT_DELAY;

    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(TOTAL - 1);
    localparam logic [CW-1:0] CNT_TOTAL  = CW'(TOTAL);
    localparam logic [CW-1:0] CNT_TRIG   = CW'(MEMORY_SIZE);
    localparam logic [CW-1:0] CNT_WIN_LO = CW'(WIN_LO);

    // The memory read path returns the word written MEMORY_SIZE+ALIGNMENT_DELAY-1
    // samples earlier, so the expected value is a fixed modular offset of data_in.
    localparam logic [DATA_WIDTH-1:0] EXP_OFS =
        DATA_WIDTH'(MEMORY_SIZE + ALIGNMENT_DELAY - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    // State and sample-counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter logic; abort outranks wr_ready while running.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = CNT_ZERO;
                if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (wr_ready) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = r_cnt;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Outputs decoded from the registered state and counter only, so they hold during stalls.
    always_comb begin
        wr_en        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        data_in      = {DATA_WIDTH{1'b0}};
        trigger_out  = 1'b0;
        check_window = 1'b0;
        expected_out = {DATA_WIDTH{1'b0}};
        case (r_state)
            ST_IDLE: begin
                done = 1'b0;
            end
            ST_RUN: begin
                wr_en        = 1'b1;
                busy         = 1'b1;
                data_in      = DATA_WIDTH'(r_cnt);
                trigger_out  = (r_cnt == CNT_TRIG);
                // Window bounds use the full counter so a wrapped data_in cannot alias.
                check_window = (r_cnt >= CNT_WIN_LO) && (r_cnt < CNT_TOTAL);
                expected_out = DATA_WIDTH'(r_cnt) - EXP_OFS;
            end
            ST_FINISH: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen: a default instance and a narrow wrapping instance.
module tb_test_pattern_gen;

    localparam int A_DW = 8, A_MEM = 32, A_HO = 8, A_AD = 1;
    localparam int B_DW = 5, B_MEM = 16, B_HO = 8, B_AD = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic wr_ready = 1'b0;
    logic sel = 1'b0;

    logic            a_wr_en, a_trig, a_cw, a_busy, a_done;
    logic [A_DW-1:0] a_data, a_exp;
    logic            b_wr_en, b_trig, b_cw, b_busy, b_done;
    logic [B_DW-1:0] b_data, b_exp;

    logic       o_wr_en, o_trig, o_cw, o_busy, o_done;
    logic [7:0] o_data, o_exp;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int d;
        int trig;
        int cw;
        int e;
    } exp_t;
    exp_t sb[$];

    typedef enum int {M_IDLE, M_RUN, M_FIN} mst_t;
    mst_t mst = M_IDLE;

    test_pattern_gen #(.DATA_WIDTH(A_DW), .MEMORY_SIZE(A_MEM),
                       .USER_HOLDOFF(A_HO), .ALIGNMENT_DELAY(A_AD)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .wr_ready(wr_ready),
        .wr_en(a_wr_en), .data_in(a_data), .trigger_out(a_trig), .check_window(a_cw),
        .expected_out(a_exp), .busy(a_busy), .done(a_done)
    );

    test_pattern_gen #(.DATA_WIDTH(B_DW), .MEMORY_SIZE(B_MEM),
                       .USER_HOLDOFF(B_HO), .ALIGNMENT_DELAY(B_AD)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .wr_ready(wr_ready),
        .wr_en(b_wr_en), .data_in(b_data), .trigger_out(b_trig), .check_window(b_cw),
        .expected_out(b_exp), .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (sel == 1'b0) begin
            o_wr_en = a_wr_en; o_trig = a_trig; o_cw = a_cw; o_busy = a_busy; o_done = a_done;
            o_data  = a_data;  o_exp  = a_exp;
        end else begin
            o_wr_en = b_wr_en; o_trig = b_trig; o_cw = b_cw; o_busy = b_busy; o_done = b_done;
            o_data  = {3'b000, b_data};
            o_exp   = {3'b000, b_exp};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected words for one complete run of the currently observed instance.
    task automatic load_run();
        int mem, ho, ad, dw, total, m;
        exp_t x;
        mem = (sel == 1'b0) ? A_MEM : B_MEM;
        ho  = (sel == 1'b0) ? A_HO  : B_HO;
        ad  = (sel == 1'b0) ? A_AD  : B_AD;
        dw  = (sel == 1'b0) ? A_DW  : B_DW;
        total = 2 * mem + ho + ad;
        m = 1 << dw;
        for (int i = 0; i < total; i++) begin
            x.d    = i % m;
            x.trig = (i == mem) ? 1 : 0;
            x.cw   = (i >= mem + ho + ad && i < total) ? 1 : 0;
            x.e    = (((i + 1 - mem - ad) % m) + m) % m;
            sb.push_back(x);
        end
    endtask

    // Compare current outputs with the model, advance the model, then cross one clock edge.
    task automatic tick();
        mst_t nxt;
        nxt = mst;
        check_eq("wr_en", o_wr_en, mst == M_RUN);
        check_eq("busy", o_busy, mst == M_RUN);
        check_eq("done", o_done, mst == M_FIN);
        if (mst == M_RUN) begin
            check_eq("data_in", o_data, sb[0].d);
            check_eq("trigger_out", o_trig, sb[0].trig);
            check_eq("check_window", o_cw, sb[0].cw);
            check_eq("expected_out", o_exp, sb[0].e);
        end else begin
            check_eq("idle_outs", {o_data, o_exp, o_trig, o_cw}, 0);
        end
        case (mst)
            M_IDLE: begin
                if (start) begin
                    sb.delete();
                    load_run();
                    nxt = M_RUN;
                end
            end
            M_RUN: begin
                if (abort) begin
                    sb.delete();
                    nxt = M_IDLE;
                end else if (wr_ready) begin
                    void'(sb.pop_front());
                    if (sb.size() == 0) nxt = M_FIN;
                end
            end
            M_FIN: nxt = M_IDLE;
            default: nxt = M_IDLE;
        endcase
        @(posedge clk);
        #1;
        mst = nxt;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_idle(input int exp_len, input string tag);
        int n_wr, cyc;
        n_wr = 0;
        cyc = 0;
        while (mst != M_IDLE && cyc < 300) begin
            if (o_wr_en) n_wr++;
            abort = (mst == M_FIN);
            tick();
            cyc++;
        end
        abort = 1'b0;
        check_eq({tag, "_timeout"}, mst == M_IDLE, 1);
        check_eq({tag, "_len"}, n_wr, exp_len);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1 check_eq("async_reset_outs",
                    {o_wr_en, o_busy, o_done, o_trig, o_cw, o_data, o_exp}, 0);
        sb.delete();
        mst = M_IDLE;
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stalls;
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int stalls;
        // Reset state.
        #12 check_eq("reset_outs", {o_wr_en, o_busy, o_done, o_trig, o_cw, o_data, o_exp}, 0);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        tick();

        // Full run with wr_ready held high.
        wr_ready = 1'b1;
        start_run();
        run_to_idle(73, "full_run");
        tick();

        // Three-cycle stall at data_in=20, plus an ignored start mid-run.
        start_run();
        stalls = 0;
        while (mst == M_RUN) begin
            if (o_data == 8'd20 && stalls < 3) begin
                wr_ready = 1'b0;
                stalls++;
            end else begin
                wr_ready = 1'b1;
            end
            start = (o_data == 8'd30);
            tick();
        end
        start = 1'b0;
        wr_ready = 1'b1;
        check_eq("stall_cycles", stalls, 3);
        run_to_idle(0, "stall_tail");

        // Abort at data_in=50, abort while idle, then start+abort together.
        start_run();
        while (mst == M_RUN && o_data != 8'd50) tick();
        check_eq("abort_point", o_data, 50);
        abort = 1'b1;
        tick();
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        run_to_idle(73, "restart_run");

        // Asynchronous reset mid-run, then idle with no done pulse.
        start_run();
        while (mst == M_RUN && o_data != 8'd10) tick();
        do_reset();
        for (int i = 0; i < 4; i++) tick();

        // Narrow instance: data_in wraps 31->0, window spans cnt 25..40.
        do_reset();
        sel = 1'b1;
        tick();
        start_run();
        run_to_idle(41, "wrap_run");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
